shared_bus_responder: RTL and testbench

- Memory-side responder for the L2 shared bus. It is the target end of the operations the L2 drives on its shared operation/data buses.
- Accepts READ, WRITE, RWIM and INVALIDATE transactions and runs a snoop window, collecting the combined snoop result from other caches.
- Services reads from a backing line store, or from a HITM owner's writeback. Returns line data with configurable latency and keeps bus statistics for the test bench.

---
 rtl/shared_bus_responder.sv | 255 +++++++++++++++++++++++++
 tb/tb_shared_bus_responder.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shared_bus_responder.sv
// Memory-side responder for the L2 shared bus.
// Accepts READ / WRITE / RWIM / INVALIDATE, runs a snoop window, serves lines
// from a direct-mapped backing store (or a HITM owner's writeback) and keeps
// per-opcode event counters.
//
// Handshake: a transaction transfers on a rising edge where opValid && opReady.
// opReady is high in IDLE, and in WAIT_WB only for the matching writeback.
// respValid is a one-cycle pulse with no backpressure; respData/respShared
// hold their values until the next response.
module shared_bus_responder #(
  parameter int addressSize  = 32,
  parameter int lineSize     = 512,
  parameter int byteSelect   = 6,
  parameter int memIndexBits = 6,
  parameter int snoopLatency = 2,
  parameter int memLatency   = 4,
  parameter int wbTimeout    = 16
) (
  input  logic                   clock,
  input  logic                   resetN,
  input  logic                   opValid,
  input  logic [7:0]             opCode,
  input  logic [addressSize-1:0] address,
  input  logic [lineSize-1:0]    writeData,
  output logic                   opReady,
  input  logic [1:0]             snoopResult,
  output logic                   respValid,
  output logic [lineSize-1:0]    respData,
  output logic                   respShared,
  output logic                   protocolError,
  output logic [31:0]            readCount,
  output logic [31:0]            rwimCount,
  output logic [31:0]            writeCount,
  output logic [31:0]            invalidateCount,
  output logic [31:0]            hitmCount
);

  localparam int lineAddrBits = addressSize - byteSelect;
  localparam int tagBits      = lineAddrBits - memIndexBits;
  localparam int memDepth     = 1 << memIndexBits;

  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_RWIM  = 8'h4D;
  localparam logic [7:0] OP_INVAL = 8'h49;

  localparam logic [1:0] SNOOP_HIT  = 2'b01;
  localparam logic [1:0] SNOOP_HITM = 2'b10;
  localparam logic [1:0] SNOOP_RSVD = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SNOOP   = 3'd1,
    ACCESS  = 3'd2,
    WAIT_WB = 3'd3,
    RESPOND = 3'd4
  } state_t;

  state_t state, nextState;

  logic [7:0]              opLatched;
  logic [lineAddrBits-1:0] lineLatched;
  logic [lineSize-1:0]     dataLatched;
  logic [15:0]             phaseCount;
  logic [15:0]             phaseLimit;
  logic                    phaseDone;
  logic                    snoopShared;
  logic                    timedOut;
  logic                    readyEnable;
  logic                    accept;
  logic                    wbMatch;
  logic                    isReadLike;
  logic [lineAddrBits-1:0] opLine;
  logic                    unusedAddressBits;

  // Backing store: valid bits are reset, tag and data are not.
  logic [memDepth-1:0]     storeValid;
  logic [tagBits-1:0]      storeTag  [memDepth];
  logic [lineSize-1:0]     storeData [memDepth];
  logic [memIndexBits-1:0] storeIndex;
  logic [tagBits-1:0]      tagIn;
  logic                    storeHit;
  logic                    storeWrite;
  logic [lineSize-1:0]     storeWriteData;
  logic [addressSize-1:0]  fillWord;
  logic [lineSize-1:0]     fillLine;
  logic [lineSize-1:0]     readLine;

  assign opLine            = address[addressSize-1:byteSelect];
  assign unusedAddressBits = ^address[byteSelect-1:0];

  assign isReadLike = (opLatched == OP_READ) || (opLatched == OP_RWIM);
  assign wbMatch    = opValid && (opCode == OP_WRITE) && (opLine == lineLatched);
  assign accept     = opValid && opReady;

  assign storeIndex = lineLatched[memIndexBits-1:0];
  assign tagIn      = lineLatched[lineAddrBits-1:memIndexBits];
  assign storeHit   = storeValid[storeIndex] && (storeTag[storeIndex] == tagIn);
  assign fillWord   = {lineLatched, {byteSelect{1'b0}}};
  assign fillLine   = {(lineSize/32){32'(fillWord)}};
  assign readLine   = storeHit ? storeData[storeIndex] : fillLine;

  // A WRITE commits at the end of ACCESS; a HITM writeback commits on accept.
  assign storeWrite     = ((state == ACCESS) && phaseDone && (opLatched == OP_WRITE)) ||
                          ((state == WAIT_WB) && accept);
  assign storeWriteData = (state == WAIT_WB) ? writeData : dataLatched;

  assign phaseDone = (phaseCount == phaseLimit - 16'd1);

  // Cycle budget of the timed states.
  always_comb begin
    phaseLimit = 16'd1;
    case (state)
      SNOOP:   phaseLimit = 16'(snoopLatency);
      ACCESS:  phaseLimit = 16'(memLatency);
      WAIT_WB: phaseLimit = 16'(wbTimeout);
      default: phaseLimit = 16'd1;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= nextState;
  end

  // Next-state logic.
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (accept) begin
          case (opCode)
            OP_READ, OP_RWIM, OP_INVAL: nextState = SNOOP;
            OP_WRITE:                   nextState = ACCESS;
            default:                    nextState = IDLE;
          endcase
        end
      end
      SNOOP: begin
        if (phaseDone) begin
          if (opLatched == OP_INVAL)           nextState = RESPOND;
          else if (snoopResult == SNOOP_HITM)  nextState = WAIT_WB;
          else                                 nextState = ACCESS;
        end
      end
      ACCESS:  if (phaseDone) nextState = RESPOND;
      WAIT_WB: begin
        if (accept)         nextState = RESPOND;
        else if (phaseDone) nextState = ACCESS;
      end
      RESPOND: nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Handshake outputs; opReady stays low until the first edge after reset.
  always_comb begin
    opReady   = readyEnable && ((state == IDLE) || ((state == WAIT_WB) && wbMatch));
    respValid = (state == RESPOND);
  end

  // Phase counter restarts on every state change.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN)                 phaseCount <= '0;
    else if (nextState != state) phaseCount <= '0;
    else if (state == SNOOP || state == ACCESS || state == WAIT_WB)
                                 phaseCount <= phaseCount + 16'd1;
  end

  // Transaction latches, response registers, error flag and counters.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      readyEnable     <= 1'b0;
      opLatched       <= '0;
      lineLatched     <= '0;
      dataLatched     <= '0;
      snoopShared     <= 1'b0;
      timedOut        <= 1'b0;
      respData        <= '0;
      respShared      <= 1'b0;
      protocolError   <= 1'b0;
      readCount       <= '0;
      rwimCount       <= '0;
      writeCount      <= '0;
      invalidateCount <= '0;
      hitmCount       <= '0;
    end else begin
      readyEnable <= 1'b1;
      case (state)
        IDLE: begin
          if (accept) begin
            opLatched   <= opCode;
            lineLatched <= opLine;
            dataLatched <= writeData;
            snoopShared <= 1'b0;
            timedOut    <= 1'b0;
            case (opCode)
              OP_READ:  readCount       <= readCount + 32'd1;
              OP_RWIM:  rwimCount       <= rwimCount + 32'd1;
              OP_WRITE: writeCount      <= writeCount + 32'd1;
              OP_INVAL: invalidateCount <= invalidateCount + 32'd1;
              default:  protocolError   <= 1'b1;
            endcase
          end
        end
        SNOOP: begin
          if (phaseDone) begin
            snoopShared <= (snoopResult == SNOOP_HIT) || (snoopResult == SNOOP_HITM);
            if (snoopResult == SNOOP_HITM) hitmCount <= hitmCount + 32'd1;
            if (snoopResult == SNOOP_RSVD) protocolError <= 1'b1;
            if (opLatched == OP_INVAL)
              respShared <= (snoopResult == SNOOP_HIT) || (snoopResult == SNOOP_HITM);
          end
        end
        ACCESS: begin
          if (phaseDone) begin
            if (isReadLike) begin
              respData   <= readLine;
              respShared <= snoopShared && !timedOut;
            end else begin
              respShared <= 1'b0;
            end
          end
        end
        WAIT_WB: begin
          if (accept) begin
            writeCount <= writeCount + 32'd1;
            respData   <= writeData;
            respShared <= snoopShared;
          end else if (phaseDone) begin
            protocolError <= 1'b1;
            timedOut      <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Store valid bits.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN)         storeValid <= '0;
    else if (storeWrite) storeValid[storeIndex] <= 1'b1;
  end

  // Store tag and data arrays.
  always_ff @(posedge clock) begin
    if (storeWrite) begin
      storeTag[storeIndex]  <= tagIn;
      storeData[storeIndex] <= storeWriteData;
    end
  end

endmodule

// File: tb/tb_shared_bus_responder.sv
// Bench for shared_bus_responder: directed scenarios followed by randomized
// transactions, checked against a line-addressed memory model.
module tb_shared_bus_responder;

  localparam int SL  = 2;
  localparam int ML  = 4;
  localparam int WBT = 16;

  localparam logic [7:0] OP_R = 8'h52;
  localparam logic [7:0] OP_W = 8'h57;
  localparam logic [7:0] OP_M = 8'h4D;
  localparam logic [7:0] OP_I = 8'h49;

  logic         clock = 1'b0;
  logic         resetN = 1'b0;
  logic         opValid = 1'b0;
  logic [7:0]   opCode = 8'h0;
  logic [31:0]  address = 32'h0;
  logic [511:0] writeData = '0;
  logic [1:0]   snoopResult = 2'b00;
  logic         opReady;
  logic         respValid;
  logic [511:0] respData;
  logic         respShared;
  logic         protocolError;
  logic [31:0]  readCount, rwimCount, writeCount, invalidateCount, hitmCount;

  shared_bus_responder dut (
    .clock(clock), .resetN(resetN), .opValid(opValid), .opCode(opCode),
    .address(address), .writeData(writeData), .opReady(opReady),
    .snoopResult(snoopResult), .respValid(respValid), .respData(respData),
    .respShared(respShared), .protocolError(protocolError),
    .readCount(readCount), .rwimCount(rwimCount), .writeCount(writeCount),
    .invalidateCount(invalidateCount), .hitmCount(hitmCount)
  );

  // Clock and watchdog.
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: memory keyed by full line address, direct-mapped
  // displacement applied on write; expected responses queued at accept.
  logic [511:0] mem_model [logic [25:0]];
  logic [511:0] exp_q[$];
  logic [511:0] last_resp;
  logic         exp_err;
  int exp_reads, exp_rwims, exp_writes, exp_invals, exp_hitms;
  int vectors;
  int miscompares;

  function automatic logic [511:0] fill_of(logic [31:0] a);
    logic [31:0] w;
    w = {a[31:6], 6'b0};
    return {16{w}};
  endfunction

  function automatic logic [511:0] model_read(logic [31:0] a);
    if (mem_model.exists(a[31:6])) return mem_model[a[31:6]];
    return fill_of(a);
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [511:0] d);
    logic [25:0] line;
    logic [25:0] k;
    logic [25:0] victims[$];
    line = a[31:6];
    if (mem_model.first(k)) begin
      do begin
        if (k[5:0] == line[5:0] && k != line) victims.push_back(k);
      end while (mem_model.next(k));
    end
    foreach (victims[i]) mem_model.delete(victims[i]);
    mem_model[line] = d;
  endtask

  task automatic model_reset();
    mem_model.delete();
    exp_q.delete();
    last_resp = '0;
    exp_err = 1'b0;
    exp_reads = 0; exp_rwims = 0; exp_writes = 0; exp_invals = 0; exp_hitms = 0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_counters(input string where);
    check({where, "_read_count"},  512'(readCount),       512'(exp_reads));
    check({where, "_rwim_count"},  512'(rwimCount),       512'(exp_rwims));
    check({where, "_write_count"}, 512'(writeCount),      512'(exp_writes));
    check({where, "_inval_count"}, 512'(invalidateCount), 512'(exp_invals));
    check({where, "_hitm_count"},  512'(hitmCount),       512'(exp_hitms));
    check({where, "_proto_err"},   512'(protocolError),   512'(exp_err));
  endtask

  task automatic check_all_zero(input string where);
    check({where, "_op_ready"},    512'(opReady),    '0);
    check({where, "_resp_valid"},  512'(respValid),  '0);
    check({where, "_resp_data"},   respData,         '0);
    check({where, "_resp_shared"}, 512'(respShared), '0);
    check_counters(where);
  endtask

  // Transaction that completes without a HITM writeback.
  task automatic do_txn(input logic [7:0] op, input logic [31:0] addr,
                        input logic [511:0] data, input logic [1:0] snoop);
    int lat;
    int n;
    logic exp_sh;
    logic [511:0] exp_d;
    opValid = 1'b1; opCode = op; address = addr; writeData = data; snoopResult = snoop;
    #1 check("op_ready_idle", 512'(opReady), 512'(1));
    tick();
    opValid = 1'b0;
    exp_sh = 1'b0;
    exp_d  = last_resp;
    case (op)
      OP_W: begin exp_writes++; model_write(addr, data); lat = ML; end
      OP_I: begin exp_invals++; lat = SL; exp_sh = (snoop == 2'b01 || snoop == 2'b10); end
      default: begin
        if (op == OP_R) exp_reads++; else exp_rwims++;
        lat = SL + ML;
        exp_sh = (snoop == 2'b01);
        exp_d = model_read(addr);
      end
    endcase
    if (op != OP_W && snoop == 2'b10) exp_hitms++;
    if (op != OP_W && snoop == 2'b11) exp_err = 1'b1;
    exp_q.push_back(exp_d);
    last_resp = exp_d;
    n = 0;
    while (n < lat + 10 && !respValid) begin
      tick();
      n++;
    end
    check("resp_latency", 512'(n), 512'(lat));
    exp_d = exp_q.pop_front();
    check("resp_data", respData, exp_d);
    check("resp_shared", 512'(respShared), 512'(exp_sh));
    tick();
    check("resp_pulse_end", 512'(respValid), 512'(0));
    snoopResult = 2'b00;
  endtask

  // READ/RWIM with HITM served by a writeback, optionally preceded by a
  // write to another line that must be held off.
  task automatic do_hitm(input logic [7:0] op, input logic [31:0] addr,
                         input logic [511:0] wb, input int delay, input bit wrong);
    opValid = 1'b1; opCode = op; address = addr; snoopResult = 2'b10;
    #1 check("hitm_op_ready", 512'(opReady), 512'(1));
    tick();
    opValid = 1'b0;
    if (op == OP_R) exp_reads++; else exp_rwims++;
    exp_hitms++;
    repeat (SL) tick();
    check("wait_wb_quiet", 512'(respValid), 512'(0));
    repeat (delay) tick();
    if (wrong) begin
      opValid = 1'b1; opCode = OP_W; address = addr ^ 32'h0000_1000; writeData = ~wb;
      #1 check("wb_wrong_held_off", 512'(opReady), 512'(0));
      tick();
      check("wb_wrong_no_resp", 512'(respValid), 512'(0));
    end
    opValid = 1'b1; opCode = OP_W; address = addr; writeData = wb;
    #1 check("wb_ready", 512'(opReady), 512'(1));
    tick();
    opValid = 1'b0;
    exp_writes++;
    model_write(addr, wb);
    last_resp = wb;
    exp_q.push_back(wb);
    check("wb_resp_valid", 512'(respValid), 512'(1));
    check("wb_resp_data", respData, exp_q.pop_front());
    check("wb_resp_shared", 512'(respShared), 512'(1));
    tick();
    check("wb_resp_pulse_end", 512'(respValid), 512'(0));
    snoopResult = 2'b00;
  endtask

  logic [511:0] rnd_data;
  logic [31:0]  rnd_addr;
  int           sel;
  int           n;

  initial begin
    vectors = 0;
    miscompares = 0;
    model_reset();

    // Reset state.
    #1 check_all_zero("reset");
    tick(); tick();
    resetN = 1'b1;
    tick();
    check("ready_after_reset", 512'(opReady), 512'(1));

    // Empty-store read returns the fill pattern.
    do_txn(OP_R, 32'h0000_1040, '0, 2'b00);
    check_counters("t1");

    // Write then read back with a sharing snoop.
    do_txn(OP_W, 32'h0000_1040, {64{8'hA5}}, 2'b00);
    do_txn(OP_R, 32'h0000_1040, '0, 2'b01);
    check_counters("t2");

    // RWIM with HITM, wrong-address write held off, writeback served.
    do_hitm(OP_M, 32'h0000_2000, 512'h1234, 2, 1'b1);
    check_counters("t3");

    // HITM with no writeback: timeout, then served from the store.
    opValid = 1'b1; opCode = OP_R; address = 32'h0000_5000; snoopResult = 2'b10;
    #1 check("to_op_ready", 512'(opReady), 512'(1));
    tick();
    opValid = 1'b0;
    exp_reads++; exp_hitms++;
    exp_q.push_back(model_read(32'h0000_5000));
    repeat (SL + WBT - 1) tick();
    check("to_err_before", 512'(protocolError), 512'(0));
    tick();
    exp_err = 1'b1;
    check("to_err_set", 512'(protocolError), 512'(1));
    n = SL + WBT;
    while (n < SL + WBT + ML + 10 && !respValid) begin
      tick();
      n++;
    end
    check("to_latency", 512'(n), 512'(SL + WBT + ML));
    last_resp = exp_q.pop_front();
    check("to_resp_data", respData, last_resp);
    check("to_resp_shared", 512'(respShared), 512'(0));
    tick();
    snoopResult = 2'b00;
    check_counters("t4");

    // Unknown opcode: accepted, error, no response, ready stays high.
    opValid = 1'b1; opCode = 8'h58; address = 32'h0000_0100;
    #1 check("bad_op_ready", 512'(opReady), 512'(1));
    tick();
    opValid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("bad_op_no_resp", 512'(respValid), 512'(0));
      check("bad_op_ready_after", 512'(opReady), 512'(1));
      tick();
    end
    do_txn(OP_I, 32'h0000_0100, '0, 2'b00);
    check_counters("t5");

    // Store aliasing: same index, different tag displaces the entry.
    do_txn(OP_W, 32'h0000_0140, {16{32'hCAFE_0001}}, 2'b00);
    do_txn(OP_W, 32'h0004_0140, {16{32'hBEEF_0002}}, 2'b00);
    do_txn(OP_R, 32'h0000_0140, '0, 2'b00);
    do_txn(OP_M, 32'h0004_0140, '0, 2'b01);

    // Randomized traffic over a small set of lines to force hits and aliasing.
    for (int t = 0; t < 40; t++) begin
      rnd_addr = ($urandom_range(0, 3) << 12) | ($urandom_range(0, 3) << 6) | $urandom_range(0, 63);
      for (int w = 0; w < 16; w++) rnd_data[w*32 +: 32] = $urandom();
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2: do_txn(OP_W, rnd_addr, rnd_data, 2'($urandom_range(0, 3)));
        5:       do_txn(OP_M, rnd_addr, '0, 2'($urandom_range(0, 1)));
        6:       do_txn(OP_I, rnd_addr, '0, 2'($urandom_range(0, 3)));
        7:       do_hitm(($urandom_range(0, 1) == 0) ? OP_R : OP_M, rnd_addr, rnd_data,
                         $urandom_range(0, 6), 1'($urandom_range(0, 1)));
        default: do_txn(OP_R, rnd_addr, '0, 2'($urandom_range(0, 1)));
      endcase
    end
    check_counters("random");

    // Reset in the middle of a read's ACCESS phase.
    opValid = 1'b1; opCode = OP_R; address = 32'h0000_1040; snoopResult = 2'b00;
    tick();
    opValid = 1'b0;
    repeat (SL + 1) tick();
    resetN = 1'b0;
    model_reset();
    #1 check_all_zero("mid_reset");
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_no_resp", 512'(respValid), 512'(0));
    end
    resetN = 1'b1;
    tick();
    do_txn(OP_R, 32'h0000_1040, '0, 2'b00);
    check_counters("t6");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
